spi_master_arbiter: RTL and testbench

//  Shares one spi_master instance between NUM_REQ on-chip requesters.

---
 rtl/spi_master_arbiter.sv | 153 +++++++++++++++
 tb/tb_spi_master_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one spi_master between NUM_REQ requesters.
// Latches the winner's operands, issues rw_start, waits for rw_ack or timeout, returns rdata/done.
module spi_master_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 8,
   parameter int TIMEOUT_CYC = 4096,
   parameter int GAP_CYC     = 4
) (
   input  logic                          sys_clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            done,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic                          err,
   output logic                          busy,
   output logic                          m_rw_start,
   output logic [ADDR_WIDTH-1:0]         m_addr,
   output logic [DATA_WIDTH-1:0]         m_txdata,
   input  logic                          m_rw_ack,
   input  logic [DATA_WIDTH-1:0]         m_rxdata
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int TO_W  = $clog2(TIMEOUT_CYC);
   localparam int GAP_W = $clog2(GAP_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_DONE,
      S_GAP
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [PTR_W-1:0]        r_ptr;
   logic [TO_W-1:0]         r_to_cnt;
   logic [GAP_W-1:0]        r_gap_cnt;
   logic [NUM_REQ-1:0]      r_grant;
   logic [NUM_REQ-1:0]      r_done;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic                    r_err;
   logic                    r_rw_start;
   logic [ADDR_WIDTH-1:0]   r_m_addr;
   logic [DATA_WIDTH-1:0]   r_m_txdata;

   logic                    w_found;
   logic [PTR_W-1:0]        w_winner;
   logic [PTR_W-1:0]        w_ptr_next;
   logic                    w_to_hit;
   logic                    w_gap_end;

   assign w_to_hit   = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
   assign w_gap_end  = (r_gap_cnt == GAP_W'(GAP_CYC - 1));
   assign w_ptr_next = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin : comb_fsm
      int idx;
      w_next   = r_state;
      w_found  = 1'b0;
      w_winner = '0;
      idx      = 0;

      // First set request at or above the pointer, wrapping modulo NUM_REQ.
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(r_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!w_found && req[idx[PTR_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = idx[PTR_W-1:0];
         end
      end

      case (r_state)
         S_IDLE:  if (w_found) w_next = S_START;
         S_START: w_next = S_WAIT;
         S_WAIT:  if (m_rw_ack || w_to_hit) w_next = S_DONE;
         S_DONE:  w_next = S_GAP;
         S_GAP:   if (w_gap_end) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= '0;
         r_to_cnt   <= '0;
         r_gap_cnt  <= '0;
         r_grant    <= '0;
         r_done     <= '0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
         r_rw_start <= 1'b0;
         r_m_addr   <= '0;
         r_m_txdata <= '0;
      end else begin
         r_rw_start <= 1'b0;
         r_done     <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant    <= NUM_REQ'(1) << w_winner;
                  r_m_addr   <= req_addr[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
                  r_m_txdata <= req_wdata[w_winner*DATA_WIDTH +: DATA_WIDTH];
                  r_ptr      <= w_ptr_next;
                  r_rw_start <= 1'b1;
               end
            end
            S_START: r_to_cnt <= '0;
            S_WAIT: begin
               r_to_cnt <= r_to_cnt + 1'b1;
               // Ack takes priority over a timeout landing on the same cycle.
               if (m_rw_ack) begin
                  r_rdata <= m_rxdata;
                  r_err   <= 1'b0;
                  r_done  <= r_grant;
               end else if (w_to_hit) begin
                  r_err   <= 1'b1;
                  r_done  <= r_grant;
               end
            end
            S_DONE: begin
               r_grant   <= '0;
               r_gap_cnt <= '0;
            end
            S_GAP:   r_gap_cnt <= r_gap_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   assign grant      = r_grant;
   assign done       = r_done;
   assign rdata      = r_rdata;
   assign err        = r_err;
   assign busy       = (r_state != S_IDLE);
   assign m_rw_start = r_rw_start;
   assign m_addr     = r_m_addr;
   assign m_txdata   = r_m_txdata;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter: directed transfers push expected starts/dones,
// a monitor compares them against DUT output events.
module tb_spi_master_arbiter;

   localparam int NR = 4;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int TO = 64;
   localparam int GC = 4;

   typedef struct packed {
      logic [NR-1:0] grant;
      logic [AW-1:0] addr;
      logic [DW-1:0] tx;
   } start_t;

   typedef struct packed {
      logic [NR-1:0] grant;
      logic [DW-1:0] rdata;
      logic          err;
   } done_t;

   logic             sys_clk = 1'b0;
   logic             rst_n;
   logic [NR-1:0]    req;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_wdata;
   logic [NR-1:0]    grant;
   logic [NR-1:0]    done;
   logic [DW-1:0]    rdata;
   logic             err;
   logic             busy;
   logic             m_rw_start;
   logic [AW-1:0]    m_addr;
   logic [DW-1:0]    m_txdata;
   logic             m_rw_ack;
   logic [DW-1:0]    m_rxdata;

   logic             slave_ack;
   logic [DW-1:0]    slave_rx;
   logic             inj_ack;
   logic [DW-1:0]    inj_data;
   logic             ack_en;
   int               ack_delay;
   logic             use_addr;
   logic [DW-1:0]    slave_data;

   start_t           start_q[$];
   done_t            done_q[$];
   int               n_checks = 0;
   int               n_fail   = 0;

   assign m_rw_ack = slave_ack | inj_ack;
   assign m_rxdata = inj_ack ? inj_data : slave_rx;

   spi_master_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYC(TO), .GAP_CYC(GC)
   ) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
      .grant(grant), .done(done), .rdata(rdata), .err(err), .busy(busy),
      .m_rw_start(m_rw_start), .m_addr(m_addr), .m_txdata(m_txdata),
      .m_rw_ack(m_rw_ack), .m_rxdata(m_rxdata)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Slave model: acks ack_delay cycles after seeing rw_start.
   initial begin
      slave_ack = 1'b0;
      slave_rx  = '0;
      forever begin
         @(negedge sys_clk);
         if (rst_n && m_rw_start && ack_en) begin
            repeat (ack_delay) @(posedge sys_clk);
            #1;
            slave_ack = 1'b1;
            slave_rx  = use_addr ? (16'hB000 | {8'h00, m_addr}) : slave_data;
            @(posedge sys_clk);
            #1;
            slave_ack = 1'b0;
         end
      end
   end

   // Monitor: every start/done event pops and compares one expectation.
   initial begin
      start_t s;
      done_t  d;
      forever begin
         @(negedge sys_clk);
         if (m_rw_start) begin
            if (start_q.size() == 0) check("unexpected_start", 32'd1, 32'd0);
            else begin
               s = start_q.pop_front();
               check("start_grant", 32'(grant), 32'(s.grant));
               check("start_addr", 32'(m_addr), 32'(s.addr));
               check("start_txdata", 32'(m_txdata), 32'(s.tx));
            end
         end
         if (done != '0) begin
            if (done_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
            else begin
               d = done_q.pop_front();
               check("done_vec", 32'(done), 32'(d.grant));
               check("done_grant_held", 32'(grant), 32'(d.grant));
               check("done_rdata", 32'(rdata), 32'(d.rdata));
               check("done_err", 32'(err), 32'(d.err));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   task automatic push_start(input logic [NR-1:0] g, input logic [AW-1:0] a, input logic [DW-1:0] t);
      start_t s;
      s.grant = g; s.addr = a; s.tx = t;
      start_q.push_back(s);
   endtask

   task automatic push_done(input logic [NR-1:0] g, input logic [DW-1:0] r, input logic e);
      done_t d;
      d.grant = g; d.rdata = r; d.err = e;
      done_q.push_back(d);
   endtask

   task automatic apply_reset();
      #1;
      rst_n = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Returns at the negedge of the START cycle.
   task automatic wait_start(input string name);
      int n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!m_rw_start && n < 200);
      if (!m_rw_start) check({name, "_start_timeout"}, 32'd0, 32'd1);
   endtask

   // Counts negedges from the current one until done appears.
   task automatic count_to_done(output int n);
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (done == '0 && n < 200);
   endtask

   task automatic wait_quiet(input string name);
      int n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while ((busy || done_q.size() != 0) && n < 300);
      check({name, "_quiet"}, 32'(done_q.size() + start_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      int low;
      int starts;
      rst_n = 1'b0; req = '0; req_addr = '0; req_wdata = '0;
      inj_ack = 1'b0; inj_data = '0; ack_en = 1'b1; ack_delay = 3;
      use_addr = 1'b0; slave_data = '0;
      apply_reset();

      // Reset state
      @(negedge sys_clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_done_err_busy", {29'd0, |done, err, busy}, 32'd0);
      check("rst_m_start", 32'(m_rw_start), 32'd0);
      check("rst_m_ops", {m_addr, m_txdata}, 32'd0);

      // 1 Single transfer
      req_addr[0*AW +: AW] = 8'h3C; req_wdata[0*DW +: DW] = 16'h1234; slave_data = 16'h2222;
      push_start(4'b0001, 8'h3C, 16'h1234);
      push_done(4'b0001, 16'h2222, 1'b0);
      @(posedge sys_clk); #1 req = 4'b0001;
      @(negedge sys_clk);
      check("t1_no_start_same_cycle", 32'(m_rw_start), 32'd0);
      @(negedge sys_clk);
      check("t1_start_latency", 32'(m_rw_start), 32'd1);
      req = '0;
      wait_quiet("t1");

      // 2 Round robin with all requests held
      apply_reset();
      for (int i = 0; i < NR; i++) begin
         req_addr[i*AW +: AW]  = AW'(8'h10 + i);
         req_wdata[i*DW +: DW] = DW'(16'hA000 + i);
      end
      use_addr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push_start(NR'(1) << (i % NR), AW'(8'h10 + (i % NR)), DW'(16'hA000 + (i % NR)));
         push_done(NR'(1) << (i % NR), DW'(16'hB010 + (i % NR)), 1'b0);
      end
      @(posedge sys_clk); #1 req = 4'b1111;
      wait_start("t2");
      starts = 1; low = 0; n = 0;
      while (starts < 5 && n < 200) begin
         @(negedge sys_clk);
         n++;
         if (!busy) low++;
         if (m_rw_start) starts++;
      end
      req = '0;
      check("t2_starts", 32'(starts), 32'd5);
      check("t2_idle_cycles", 32'(low), 32'd4);
      wait_quiet("t2");

      // 3 Timeout, then normal completion
      use_addr = 1'b0; ack_en = 1'b0;
      req_addr[2*AW +: AW] = 8'h77; req_wdata[2*DW +: DW] = 16'h5555;
      push_start(4'b0100, 8'h77, 16'h5555);
      push_done(4'b0100, 16'hB010, 1'b1);
      @(posedge sys_clk); #1 req = 4'b0100;
      wait_start("t3");
      req = '0;
      count_to_done(n);
      check("t3_timeout_latency", 32'(n), 32'd65);
      wait_quiet("t3a");
      ack_en = 1'b1; slave_data = 16'h6666;
      push_start(4'b0100, 8'h77, 16'h5555);
      push_done(4'b0100, 16'h6666, 1'b0);
      @(posedge sys_clk); #1 req = 4'b0100;
      wait_start("t3b");
      req = '0;
      wait_quiet("t3b");

      // 4 Operand stability and stray ack in GAP
      ack_delay = 10; slave_data = 16'h7777;
      req_addr[1*AW +: AW] = 8'h21; req_wdata[1*DW +: DW] = 16'h1234;
      push_start(4'b0010, 8'h21, 16'h1234);
      push_done(4'b0010, 16'h7777, 1'b0);
      @(posedge sys_clk); #1 req = 4'b0010;
      wait_start("t4");
      req = '0; req_wdata[1*DW +: DW] = 16'h4321;
      repeat (3) @(negedge sys_clk);
      check("t4_txdata_in_wait", 32'(m_txdata), 32'h1234);
      count_to_done(n);
      @(posedge sys_clk); #1 inj_ack = 1'b1; inj_data = 16'hDEAD;
      @(posedge sys_clk); #1 inj_ack = 1'b0;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge sys_clk);
         if (done != '0) n++;
      end
      check("t4_stray_ack_dones", 32'(n), 32'd0);
      check("t4_rdata_kept", 32'(rdata), 32'h7777);
      check("t4_txdata_after", 32'(m_txdata), 32'h1234);
      check("t4_idle", 32'(busy), 32'd0);

      // 5 Reset mid-WAIT
      ack_en = 1'b0; ack_delay = 3;
      req_addr[3*AW +: AW] = 8'h33; req_wdata[3*DW +: DW] = 16'h3333;
      push_start(4'b1000, 8'h33, 16'h3333);
      @(posedge sys_clk); #1 req = 4'b1000;
      wait_start("t5");
      req = 4'b0110;
      repeat (2) @(posedge sys_clk);
      #1 rst_n = 1'b0;
      @(negedge sys_clk);
      check("t5_rst_grant_done", {24'd0, grant, done}, 32'd0);
      check("t5_rst_flags", {29'd0, err, busy, m_rw_start}, 32'd0);
      check("t5_rst_rdata", 32'(rdata), 32'd0);
      check("t5_rst_ops", {m_addr, m_txdata}, 32'd0);
      ack_en = 1'b1; slave_data = 16'h8888;
      push_start(4'b0010, 8'h21, 16'h4321);
      push_done(4'b0010, 16'h8888, 1'b0);
      repeat (2) @(posedge sys_clk);
      #1 rst_n = 1'b1;
      wait_start("t5b");
      req = '0;
      wait_quiet("t5");

      // 6 Ack and timeout on the same cycle
      ack_en = 1'b0;
      push_start(4'b0100, 8'h77, 16'h5555);
      push_done(4'b0100, 16'h4344, 1'b0);
      @(posedge sys_clk); #1 req = 4'b0100;
      wait_start("t6");
      req = '0;
      repeat (TO) @(posedge sys_clk);
      #1 inj_ack = 1'b1; inj_data = 16'h4344;
      @(posedge sys_clk); #1 inj_ack = 1'b0;
      @(negedge sys_clk);
      check("t6_done_at_limit", 32'(done), 32'b0100);
      wait_quiet("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
